// File: rtl/fa_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM encoding.
package fa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa4_mbit.sv
// 4-bit ripple full adder stage: {co, s} = a + b + ci.
module fa4_mbit (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one fa4_mbit, one nibble per clock, LSB first.
module nibble_serial_adder
    import fa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        ci,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] s,
    output logic                        co
);

    localparam int W    = NIBBLE_W * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      s_q, s_d;
    logic              co_q, co_d;
    logic              done_q, done_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] fa_s;
    logic                fa_co;
    logic                last_nib;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    fa4_mbit u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q)
    );

    assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start directly for back-to-back use
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[i*NIBBLE_W +: NIBBLE_W] = fa_s;
                    end
                end
                carry_d = fa_co;
                idx_d   = idx_q + IDXW'(1);
                if (last_nib) begin
                    co_d    = fa_co;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1).
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;

    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        ci1;
    logic        busy1;
    logic        done1;
    logic [3:0]  s1;
    logic        co1;

    int errors;
    int checks;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ci    (ci1),
        .busy  (busy1),
        .done  (done1),
        .s     (s1),
        .co    (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; ci = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, co, s} !== 19'd0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b co=%b s=%h expected all zero", busy, done, co, s);
        end
        checks++;
        if ({busy1, done1, co1, s1} !== 7'd0) begin
            errors++;
            $display("FAIL reset1 busy=%b done=%b co=%b s=%h expected all zero", busy1, done1, co1, s1);
        end
    endtask

    task automatic test_basic();
        a = 16'h1234; b = 16'h4321; ci = 1'b1; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            a = 16'h0000; b = 16'h0000; ci = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle %0d busy=%b done=%b expected busy=1 done=0", k, busy, done);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s !== 16'h5556 || co !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b busy=%b s=%h co=%b expected 1 0 5556 0", done, busy, s, co);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s !== 16'h5556 || co !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold done=%b busy=%b s=%h co=%b expected 0 0 5556 0", done, busy, s, co);
        end
    endtask

    task automatic test_carry();
        a = 16'hFFFF; b = 16'h0001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b1 || s !== 16'h0000 || co !== 1'b1) begin
            errors++;
            $display("FAIL carry_ripple done=%b s=%h co=%b expected 1 0000 1", done, s, co);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        a = 16'h1111; b = 16'h2222; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy busy=%b expected 1", busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || s !== 16'h3333 || co !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result done=%b s=%h co=%b expected 1 3333 0", done, s, co);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 16'h1234; b = 16'h4321; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (s !== 16'h0000 || co !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort s=%h co=%b busy=%b done=%b expected 0000 0 0 0", s, co, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_no_done done pulses=%0d expected 0", seen);
        end
        a = 16'h00FF; b = 16'h0001; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 1 || s !== 16'h0100 || co !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart seen=%0d s=%h co=%b expected 1 0100 0", seen, s, co);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b1 || s !== 16'h2345 || co !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first done=%b s=%h co=%b expected 1 2345 0", done, s, co);
        end
        a = 16'h8000; b = 16'h8000; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart busy=%b done=%b expected 1 0", busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || co !== 1'b0) begin
            errors++;
            $display("FAIL b2b_co_hold done=%b co=%b expected 0 0", done, co);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || s !== 16'h0000 || co !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second done=%b s=%h co=%b expected 1 0000 1", done, s, co);
        end
        @(negedge clk);
    endtask

    task automatic test_single_nibble();
        a1 = 4'hF; b1 = 4'hF; ci1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_busy busy=%b done=%b expected 1 0", busy1, done1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || s1 !== 4'hF || co1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_done done=%b busy=%b s=%h co=%b expected 1 0 f 1", done1, busy1, s1, co1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || s1 !== 4'hF || co1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_hold done=%b s=%h co=%b expected 0 f 1", done1, s1, co1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_single_nibble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that time-shares one 4-bit full adder, processing one nibble per clock from LSB to MSB.
- Sits directly upstream of and around the 4-bit adder stage: it latches wide operands, feeds nibble slices and the running carry into `fa4_mbit`, and consumes that stage's `s` and `co` outputs.
- Handshake is start/busy/done. The result is held until the next accepted start.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request to begin an addition; sampled only in IDLE or DONE.
- a, input, W, operand A; latched on accepted start.
- b, input, W, operand B; latched on accepted start.
- ci, input, 1, carry-in; latched on accepted start.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when the result is complete.
- s, output, W, sum register.
- co, output, 1, final carry-out register.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, nibble index=0, carry reg=0.
  - Operand regs cleared.
  - s=0, co=0, busy=0, done=0.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced for the aborted operation.
- FSM states: IDLE, RUN, DONE. Encoding comes from the shared package.
- IDLE:
  - start=1 at edge E0: latch a, b, ci; index=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, at edge E(i+1) for i=0..NIBBLES-1:
  - The adder is fed a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry reg.
  - Write its sum into s[4i+3:4i]; carry reg <= its co; index++.
  - On the edge that processes nibble NIBBLES-1: co <= adder co, done <= 1, go to DONE.
- DONE, lasting exactly one cycle:
  - done=1, busy=0, s/co valid.
  - At the next edge, done <= 0.
  - If start=1 at that edge, accept it (latch, go to RUN). Back-to-back operations are legal.
  - Otherwise go to IDLE.
- Latency: start sampled at E0, done high between E_NIBBLES and E_(NIBBLES+1). Throughput is one result per NIBBLES+1 cycles.
- start during RUN is ignored. Operand changes during RUN have no effect because operands are registered.
- During RUN, s is partially overwritten nibble by nibble. s and co are only guaranteed valid when done=1, and they hold their values through IDLE.
- co is not updated until the last nibble; it holds the previous result during RUN.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(W+1); wrap-around is natural.
- busy is a combinational decode of state==RUN. done is registered.

Decomposition:
- Shared package fa_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4.
- Sub-module: exactly one instance of the existing `fa4_mbit` (ports s, co, a, b, ci) as the datapath adder.
- Index counter width is $clog2(NIBBLES) with a minimum of 1.

Test Plan:
- NIBBLES=4; a=16'h1234, b=16'h4321, ci=1; start pulsed 1 cycle -> busy high 4 cycles, then done for 1 cycle with s=16'h5556, co=0; s/co then hold in IDLE.
- a=16'hFFFF, b=16'h0001, ci=0 -> carry ripples through all nibbles; done with s=16'h0000, co=1.
- Start accepted, then start re-pulsed with a=16'h0000 mid-RUN -> ignored; result matches the first operands.
- rst asserted at the 2nd RUN cycle -> s=0, co=0, busy=0 immediately; no done pulse; a later start with a=16'h00FF, b=16'h0001, ci=0 gives s=16'h0100, co=0.
- start held high across the DONE cycle with new operands a=16'h8000, b=16'h8000, ci=0 -> second operation starts without passing through IDLE; done pulses twice 5 cycles apart; second result s=16'h0000, co=1.
- NIBBLES=1; a=4'hF, b=4'hF, ci=1 -> done 1 cycle after the RUN edge; s=4'hF, co=1.
